// File: rtl/bram_stream_reader.sv
// Reads the circular capture BRAM behind the writer and streams fixed-size packets over AXI4-Stream.
// Optional sticky lap alarm: define READER_OVERRUN_DETECT_EN.
module bram_stream_reader #(
  parameter int BRAM_ADDR_WIDTH  = 16,
  parameter int BRAM_DEPTH_WORDS = 16384,
  parameter int PACKET_WORDS     = 144,
  parameter int OUT_BUF_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [13:0]                wr_addr,
  output logic                       bram_clk,
  output logic                       bram_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]                bram_din,
  output logic [3:0]                 bram_we,
  output logic                       bram_en,
  input  logic [31:0]                bram_dout,
  output logic [31:0]                m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [13:0]                rd_addr_o,
  output logic [14:0]                words_available,
  output logic [31:0]                packets_sent,
  output logic                       busy,
  output logic                       overrun
);

  localparam int CW = $clog2(PACKET_WORDS + 1);
  localparam int PW = $clog2(OUT_BUF_DEPTH);
  localparam int OW = $clog2(OUT_BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state, state_next;
  logic [13:0]     rd_addr;
  logic [CW-1:0]   issue_cnt;
  logic            inflight, inflight_last;
  logic [31:0]     buf_data [OUT_BUF_DEPTH];
  logic            buf_last [OUT_BUF_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [OW-1:0]   occ;
  logic            issue, pop, push;
  logic [OW:0]     used;
  logic [14:0]     wr_ext, rd_ext, wa_next;

  assign bram_clk      = clk;
  assign bram_rst      = rst;
  assign bram_addr     = BRAM_ADDR_WIDTH'({rd_addr, 2'b00});
  assign bram_din      = 32'd0;
  assign bram_we       = 4'd0;
  assign bram_en       = issue;
  assign rd_addr_o     = rd_addr;
  assign m_axis_tvalid = (occ != '0);
  assign m_axis_tdata  = buf_data[head];
  assign m_axis_tlast  = buf_last[head];
  assign busy          = (state != IDLE) || (occ != '0);

  assign pop  = m_axis_tvalid & m_axis_tready;
  assign push = inflight;
  // Slots committed after this cycle; a pop frees its slot for an issue in the same cycle.
  assign used = {1'b0, occ} + {{OW{1'b0}}, inflight} - {{OW{1'b0}}, pop};

  assign wr_ext  = {1'b0, wr_addr};
  assign rd_ext  = {1'b0, rd_addr};
  assign wa_next = (wr_ext >= rd_ext) ? (wr_ext - rd_ext)
                                      : (wr_ext + 15'(BRAM_DEPTH_WORDS) - rd_ext);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: if (enable && words_available >= 15'(PACKET_WORDS)) state_next = READ;
      READ: begin
        if (issue_cnt < CW'(PACKET_WORDS) && used < (OW+1)'(OUT_BUF_DEPTH)) issue = 1'b1;
        if (issue && issue_cnt == CW'(PACKET_WORDS - 1)) state_next = DRAIN;
      end
      DRAIN: if (pop && m_axis_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rd_addr         <= '0;
      issue_cnt       <= '0;
      inflight        <= 1'b0;
      inflight_last   <= 1'b0;
      words_available <= '0;
      packets_sent    <= '0;
    end else begin
      state           <= state_next;
      words_available <= wa_next;
      inflight        <= issue;
      inflight_last   <= issue && (issue_cnt == CW'(PACKET_WORDS - 1));
      if (state == IDLE && state_next == READ) issue_cnt <= '0;
      else if (issue)                          issue_cnt <= issue_cnt + CW'(1);
      if (issue) rd_addr <= (rd_addr == 14'(BRAM_DEPTH_WORDS - 1)) ? '0 : rd_addr + 14'd1;
      if (state == DRAIN && pop && m_axis_tlast) packets_sent <= packets_sent + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_data[tail] <= bram_dout;
        buf_last[tail] <= inflight_last;
        tail <= (tail == PW'(OUT_BUF_DEPTH - 1)) ? '0 : tail + PW'(1);
      end
      if (pop) head <= (head == PW'(OUT_BUF_DEPTH - 1)) ? '0 : head + PW'(1);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

`ifdef READER_OVERRUN_DETECT_EN
  // Writer within one packet of lapping the reader; held until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                               overrun <= 1'b0;
    else if (words_available >= 15'(BRAM_DEPTH_WORDS - PACKET_WORDS)) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: BRAM model returns C0DE_<word addr>, a monitor scoreboards the stream.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [13:0] wr_addr = '0;
  logic        bram_clk, bram_rst, bram_en;
  logic [15:0] bram_addr;
  logic [31:0] bram_din;
  logic [3:0]  bram_we;
  logic [31:0] bram_dout = '0;
  logic [31:0] tdata;
  logic        tvalid, tlast;
  logic        tready = 1'b1;
  logic [13:0] rd_addr_o;
  logic [14:0] words_available;
  logic [31:0] packets_sent;
  logic        busy, overrun;

  int checks = 0;
  int errors = 0;
  int exp_addr = 0, idx = 0, out_cnt = 0, words_rx = 0;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] overrun_exp;

  bram_stream_reader dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_addr(wr_addr),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_we(bram_we), .bram_en(bram_en), .bram_dout(bram_dout),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .rd_addr_o(rd_addr_o), .words_available(words_available), .packets_sent(packets_sent),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bram_en) bram_dout <= 32'hC0DE0000 | {18'd0, bram_addr[15:2]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_addr = 0; idx = 0; out_cnt = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tvalid), 1);
        check("stall_data", tdata, prev_data);
        check("stall_last", 32'(tlast), 32'(prev_last));
      end
      out_cnt = out_cnt + int'(bram_en) - int'(tvalid & tready);
      if (bram_en) check("outstanding_le_depth", 32'(out_cnt <= 4), 1);
      if (tvalid && tready) begin
        check("data", tdata, 32'hC0DE0000 | 32'(exp_addr));
        check("last", 32'(tlast), 32'(idx == 143));
        exp_addr = (exp_addr + 1) % 16384;
        idx = (idx == 143) ? 0 : idx + 1;
        words_rx++;
      end
      prev_stall = tvalid & ~tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    for (int i = 0; i < budget && packets_sent != 32'(n); i++) tick();
    check("packets_sent", packets_sent, 32'(n));
  endtask

  initial begin
    int k, n, base;
`ifdef READER_OVERRUN_DETECT_EN
    overrun_exp = 1;
`else
    overrun_exp = 0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_addr", 32'(rd_addr_o), 0);
    check("rst_words_avail", 32'(words_available), 0);
    check("rst_packets", packets_sent, 0);
    check("rst_bram_en", 32'(bram_en), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("bram_we", 32'(bram_we), 0);

    // One word short of a packet: nothing may start
    enable = 1'b1; wr_addr = 14'd143;
    n = 0;
    repeat (50) begin tick(); if (tvalid) n++; end
    check("below_thr_valid", n, 0);
    check("below_thr_avail", 32'(words_available), 143);

    // Threshold reached: first tvalid four edges after wr_addr moves
    wr_addr = 14'd144;
    k = 0;
    for (int i = 1; i <= 10; i++) begin tick(); if (tvalid) begin k = i; break; end end
    check("first_valid_lat", k, 4);
    n = 0;
    while (tvalid && n < 300) begin n++; tick(); end
    check("pkt_span", n, 144);
    tick(); tick();
    check("basic_packets", packets_sent, 1);
    check("basic_rd_addr", 32'(rd_addr_o), 144);
    check("basic_avail", 32'(words_available), 0);
    check("basic_busy", 32'(busy), 0);
    check("basic_words", words_rx, 144);

    // enable dropped after word 10: packet completes, nothing new starts
    base = words_rx;
    wr_addr = 14'd288;
    for (int i = 0; i < 50 && words_rx < base + 11; i++) tick();
    enable = 1'b0; wr_addr = 14'd432;
    wait_pkts(2, 400);
    n = 0;
    repeat (30) begin tick(); if (tvalid) n++; end
    check("en_drop_no_new", n, 0);
    check("en_drop_busy", 32'(busy), 0);
    check("en_drop_words", words_rx - base, 144);
    check("en_drop_avail", 32'(words_available), 144);
    check("en_drop_rd_addr", 32'(rd_addr_o), 288);

    // Backpressure 1-0-0-1
    enable = 1'b1;
    for (int ph = 0; ph < 2000 && packets_sent != 32'd3; ph++) begin
      tready = (ph % 4 == 0) || (ph % 4 == 3);
      tick();
    end
    tready = 1'b1;
    check("bp_packets", packets_sent, 3);
    check("bp_rd_addr", 32'(rd_addr_o), 432);
    check("bp_words", words_rx, 432);

    // Reset mid-packet
    base = words_rx;
    wr_addr = 14'd576;
    for (int i = 0; i < 200 && words_rx < base + 50; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_tvalid", 32'(tvalid), 0);
    check("rst_mid_rd_addr", 32'(rd_addr_o), 0);
    wr_addr = 14'd0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_busy", 32'(busy), 0);

    // Run the ring round: packet 114 spans 16272..16383, 0..31
    for (int p = 1; p <= 114; p++) begin
      wr_addr = 14'((p * 144) % 16384);
      if (p == 114) begin
        tick();
        check("wrap_avail", 32'(words_available), 144);
        check("wrap_rd_start", 32'(rd_addr_o), 16272);
      end
      wait_pkts(p, 400);
    end
    tick(); tick();
    check("wrap_rd_end", 32'(rd_addr_o), 32);
    check("wrap_avail_end", 32'(words_available), 0);

    // Headroom alarm
    rst = 1'b1; enable = 1'b0; wr_addr = 14'd16240;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("ovr_avail", 32'(words_available), 16240);
    check("ovr_set", 32'(overrun), overrun_exp);
    enable = 1'b1;
    for (int i = 0; i < 20 && !tvalid; i++) tick();
    enable = 1'b0;
    wait_pkts(1, 400);
    tick(); tick();
    check("ovr_rd_addr", 32'(rd_addr_o), 144);
    check("ovr_sticky", 32'(overrun), overrun_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
